muler_pipe: RTL

Parametrised, two-stage pipelined integer multiplier for the EX/M1/M2 pipeline, successor to the fixed 32x32 unit. It generalises operand width and slice width, adds the signed×unsigned high-half op (MULHSU), and tracks per-stage valid bits with flush and bubble insertion. It sits beside the ALU: operands are captured at the EX→M1 boundary, and the result is presented from the M2 register.

---
 rtl/mul_pkg.sv | 26 ++
 rtl/muler_slice.sv | 15 +
 rtl/muler_pipe.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and operand-signedness helpers for the pipelined multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHU  = 2'd2,
        MULHSU = 2'd3
    } mul_op_t;

    // Every op except MUL returns the upper half of the product.
    function automatic logic is_high(input mul_op_t op);
        return (op != MUL);
    endfunction

    // Operand A is treated as two's complement for MULH and MULHSU.
    function automatic logic a_signed(input mul_op_t op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    // Operand B is treated as two's complement for MULH only.
    function automatic logic b_signed(input mul_op_t op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/muler_slice.sv
// One unsigned SLICE x WIDTH partial product, intended to map onto a DSP block.
(* use_dsp = "yes" *)
module muler_slice #(
    parameter int SLICE = 16,
    parameter int WIDTH = 32
) (
    input  logic [SLICE-1:0]       i_a,
    input  logic [WIDTH-1:0]       i_b,
    output logic [SLICE+WIDTH-1:0] o_prod
);

    // Both operands zero-extended to the product width so nothing is truncated.
    assign o_prod = {{WIDTH{1'b0}}, i_a} * {{SLICE{1'b0}}, i_b};

endmodule

// File: rtl/muler_pipe.sv
// Two-stage pipelined integer multiplier (EX -> M1 -> M2) with per-stage
// valid tracking, stalls, flushes and signed/unsigned high-half ops.
module muler_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  mul_op_t          op_i,
    input  logic             valid_i,
    input  logic             ex_stall_i,
    input  logic             m1_stall_i,
    input  logic             m2_stall_i,
    input  logic             m1_flush_i,
    input  logic             m2_flush_i,
    input  logic [WIDTH-1:0] r0_i,
    input  logic [WIDTH-1:0] r1_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int PP_W   = SLICE + WIDTH;

    if (WIDTH % SLICE != 0) begin : g_bad_slice
        $error("muler_pipe: WIDTH must be a multiple of SLICE");
    end

    // ---------------- EX: partial products and sign correction
    logic [PP_W-1:0]    w_pp [NSLICE];
    logic [WIDTH-1:0]   w_hfix;
    logic               w_hi;

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        muler_slice #(
            .SLICE (SLICE),
            .WIDTH (WIDTH)
        ) u_slice (
            .i_a    (r0_i[k*SLICE +: SLICE]),
            .i_b    (r1_i),
            .o_prod (w_pp[k])
        );
    end

    assign w_hi = is_high(op_i);

    // Upper-half correction turning the unsigned product into the signed one.
    always_comb begin
        w_hfix = '0;
        if (a_signed(op_i) && r0_i[WIDTH-1]) begin
            w_hfix = w_hfix - r1_i;
        end
        if (b_signed(op_i) && r1_i[WIDTH-1]) begin
            w_hfix = w_hfix - r0_i;
        end
    end

    // ---------------- M1 registers
    logic [PP_W-1:0]  r_pp_p1 [NSLICE];
    logic [WIDTH-1:0] r_hfix_p1;
    logic             r_hi_p1;
    logic             r_vld_p1;

    // M1 capture: flush clears valid even while stalled; data only moves when not stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_hi_p1   <= 1'b0;
            r_hfix_p1 <= '0;
            for (int k = 0; k < NSLICE; k++) begin
                r_pp_p1[k] <= '0;
            end
        end else begin
            if (m1_flush_i) begin
                r_vld_p1 <= 1'b0;
            end else if (!m1_stall_i) begin
                r_vld_p1 <= valid_i & ~ex_stall_i;
            end
            if (!m1_stall_i) begin
                r_hi_p1   <= w_hi;
                r_hfix_p1 <= w_hfix;
                for (int k = 0; k < NSLICE; k++) begin
                    r_pp_p1[k] <= w_pp[k];
                end
            end
        end
    end

    // ---------------- M1 -> M2: adder tree, wraps mod 2^(2W)
    logic [2*WIDTH-1:0] w_full;
    logic [2*WIDTH-1:0] w_ext;

    // Sum of shifted partial products plus the sign correction in the upper half.
    always_comb begin
        w_full = {r_hfix_p1, {WIDTH{1'b0}}};
        w_ext  = '0;
        for (int k = 0; k < NSLICE; k++) begin
            w_ext           = '0;
            w_ext[PP_W-1:0] = r_pp_p1[k];
            w_full          = w_full + (w_ext << (k*SLICE));
        end
    end

    logic [2*WIDTH-1:0] r_full_p2;
    logic               r_hi_p2;
    logic               r_vld_p2;

    // M2 capture: a stalled M1 hands over a bubble; flush clears valid but holds data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_p2  <= 1'b0;
            r_hi_p2   <= 1'b0;
            r_full_p2 <= '0;
        end else begin
            if (m2_flush_i) begin
                r_vld_p2 <= 1'b0;
            end else if (!m2_stall_i) begin
                r_vld_p2 <= r_vld_p1 & ~m1_stall_i;
            end
            if (!m2_stall_i) begin
                r_hi_p2   <= r_hi_p1;
                r_full_p2 <= w_full;
            end
        end
    end

    assign result_o = r_hi_p2 ? r_full_p2[2*WIDTH-1:WIDTH] : r_full_p2[WIDTH-1:0];
    assign valid_o  = r_vld_p2;

    // A held M2 must never let M1 advance into it.
    a_stall_order: assert property (@(posedge clk) disable iff (!rst_n)
                                    m2_stall_i |-> m1_stall_i);

endmodule
